// File: rtl/uart_frame_parser.sv
// Parses SYNC/LEN/payload/CHK frames from a UART byte strobe into a 16-entry payload buffer.
// Status pulses appear one clock after the CHK byte; there is no backpressure, every strobed byte is consumed.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 4340
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic [3:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  output logic       o_Frame_Valid,
  output logic [4:0] o_Frame_Len,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TO  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       len_q, len_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       xor_q, xor_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [4:0]       flen_q, flen_d;
  logic [7:0]       rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             wr_en;

  logic [7:0] buf_mem [16];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    code_d  = code_q;
    flen_d  = flen_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    rd_d    = buf_mem[i_Rd_Addr];
    cnt_d   = (state_q == S_IDLE || i_Rx_DV) ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte != 8'd0 && i_Rx_Byte <= MAX_LEN_B) begin
            len_d   = i_Rx_Byte[4:0];
            xor_d   = i_Rx_Byte;
            idx_d   = 4'd0;
            state_d = S_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_Rx_DV) begin
          wr_en = 1'b1;
          xor_d = xor_q ^ i_Rx_Byte;
          idx_d = idx_q + 4'd1;
          if ({1'b0, idx_q} == len_q - 5'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == xor_q) begin
            vld_d  = 1'b1;
            flen_d = len_q;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    if (state_q != S_IDLE && !i_Rx_DV && cnt_q == TO_LAST) begin
      err_d   = 1'b1;
      code_d  = ERR_TO;
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= 5'd0;
      idx_q   <= 4'd0;
      xor_q   <= 8'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      flen_q  <= 5'd0;
      rd_q    <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      code_q  <= code_d;
      flen_q  <= flen_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  // Payload storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge i_Clock) begin
    if (wr_en) buf_mem[idx_q] <= i_Rx_Byte;
  end

  assign o_Rd_Data     = rd_q;
  assign o_Frame_Valid = vld_q;
  assign o_Frame_Len   = flen_q;
  assign o_Frame_Err   = err_q;
  assign o_Err_Code    = code_q;
  assign o_Busy        = busy_q;

endmodule
